dmem_ram_stream: RTL and testbench
==================================

Name: dmem_ram_stream

Overview:
Parametrised word-addressed data memory for the pipeline processor, replacing the fixed 129600x32 image RAM. It adds per-byte write enables, a registered read port, an out-of-range error flag, and a hardware dump engine. The dump engine streams the whole memory out over a valid/ready interface and replaces the simulation-only file dump. It sits on the MEM stage data port; the dump stream feeds the image-output path.

Parameters:
DATA_W, 32, word width in bits; must be a multiple of 8.
DEPTH, 129600, number of words; valid addresses are 0..DEPTH-1.
ADDR_W, 32, width of the CPU address port.
CNT_W, 17, dump counter width; requires 2^CNT_W >= DEPTH.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
we  in  1  CPU write enable.
be  in  DATA_W/8  byte enables; bit i writes wd[8i+7:8i].
re  in  1  CPU read request.
address  in  ADDR_W  CPU word address.
wd  in  DATA_W  CPU write data.
rd  out  DATA_W  CPU read data, registered.
rd_valid  out  1  rd holds the result of the read issued the previous cycle.
oob_err  out  1  sticky flag: an out-of-range CPU access occurred.
dump_start  in  1  single-cycle request to stream the full memory.
dump_busy  out  1  dump in progress; the CPU port is blocked.
dump_valid  out  1  dump_data/dump_addr are valid.
dump_ready  in  1  downstream accepts the word.
dump_addr  out  CNT_W  address of the word currently presented.
dump_data  out  DATA_W  word currently presented.
dump_last  out  1  asserted with the word at address DEPTH-1.

Behaviour:
- Reset values: rd=0, rd_valid=0, oob_err=0, dump_busy=0, dump_valid=0, dump_addr=0, dump_data=0, dump_last=0, FSM=IDLE. Memory contents are not reset.
- Reset asserted mid-dump: the FSM aborts to IDLE immediately and no further words are emitted.
- CPU write (IDLE only): if we=1 and address<DEPTH, each byte with be[i]=1 is written at the rising edge. Bytes with be[i]=0 are unchanged.
- CPU read (IDLE only): if re=1, rd is loaded with mem[address] and rd_valid=1 on the next cycle. rd_valid is 0 in any cycle following re=0.
- Read and write to the same address in the same cycle return the OLD data (read-before-write).
- Out of range (address>=DEPTH with we or re): the write is dropped, and the read returns rd=0 with rd_valid=1. oob_err is set and stays set until reset.
- While dump_busy=1: we and re are ignored (no write, rd_valid=0, no oob_err update).
- FSM states: IDLE, FETCH, STREAM.
  - IDLE: dump_start=1 -> FETCH, with counter=0 and dump_busy=1 from the next cycle. A dump_start that coincides with we/re still lets the CPU access complete that cycle.
  - FETCH: issue the memory read at the counter -> STREAM. dump_valid rises 2 cycles after dump_start is sampled.
  - STREAM: dump_valid=1. Data, address and last are held stable while dump_ready=0. On valid&ready the word is accepted:
    - if it was last -> IDLE (dump_busy=0 the next cycle);
    - otherwise the counter increments and the next word is presented.
  - Throughput: with dump_ready held high, one word per cycle after the first. This requires prefetch or a skid register; bubbles are not allowed.
- dump_start is ignored while dump_busy=1.
- dump_last=1 only when dump_valid=1 and dump_addr=DEPTH-1.
- The counter never wraps past DEPTH-1.
- Full dump duration with ready held high: DEPTH+1 cycles from dump_start to the final handshake.

Test Plan:
- Byte-enable write: write 0xAABBCCDD to address 5 with be=1111, then 0x11223344 with be=0101, then read 5 -> rd=0xAA22CC44, rd_valid=1 exactly one cycle after re.
- Read-before-write: at addr 7 holding 0x1, issue we (wd=0x2) and re in the same cycle -> rd=0x1; the next read of addr 7 -> rd=0x2.
- Out of range: write address=129600 (DEPTH) -> addr 129599 is unchanged, oob_err=1 and stays 1 through 10 idle cycles; a read at 200000 -> rd=0, rd_valid=1.
- Full dump, ready always high, DEPTH=16, mem[i]=i*3 -> 16 handshakes with dump_data=0,3,...,45 on consecutive cycles. dump_last only on addr 15; dump_busy falls the cycle after.
- Backpressure: DEPTH=16, toggle dump_ready with a random pattern -> no word lost or duplicated, and data/addr stay stable while ready=0. Also apply we=1 to addr 2 mid-dump -> mem[2] is unchanged after the dump.
- Reset mid-dump: assert rst_n=0 after 4 accepted words -> all outputs return to reset values asynchronously. A new dump_start after reset restarts from addr 0.

Source files
------------

// File: rtl/dmem_ram_stream.sv
// Word-addressed data memory with byte-enable writes, a registered read port,
// a sticky out-of-range flag and a valid/ready engine that streams the whole array.
module dmem_ram_stream #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 129600,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 17
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  input  logic                re,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   wd,
  output logic [DATA_W-1:0]   rd,
  output logic                rd_valid,
  output logic                oob_err,
  input  logic                dump_start,
  output logic                dump_busy,
  output logic                dump_valid,
  input  logic                dump_ready,
  output logic [CNT_W-1:0]    dump_addr,
  output logic [DATA_W-1:0]   dump_data,
  output logic                dump_last
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, FETCH, STREAM} state_e;

  state_e            state_q;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] mem_q;
  logic              rd_valid_q, rd_oob_q, oob_q;
  logic              busy_q, dvalid_q, dlast_q;
  logic [CNT_W-1:0]  daddr_q;

  logic              idle, cpu_inr, cpu_oob, mem_we, mem_re, dump_adv, at_last;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [IDX_W-1:0]  mem_raddr;

  always_comb begin
    idle      = (state_q == IDLE);
    cpu_inr   = 64'(address) < 64'(DEPTH);
    cpu_oob   = idle && (we || re) && !cpu_inr;
    at_last   = (daddr_q == LAST_ADDR);
    cnt_nxt   = daddr_q + CNT_W'(1);
    // Prefetch: the next word is read in the same cycle the current one is accepted.
    dump_adv  = (state_q == FETCH) || (state_q == STREAM && dump_ready && !at_last);
    mem_we    = idle && we && cpu_inr;
    mem_re    = (idle && re && cpu_inr) || dump_adv;
    mem_raddr = address[IDX_W-1:0];
    if (state_q == FETCH)       mem_raddr = daddr_q[IDX_W-1:0];
    else if (state_q == STREAM) mem_raddr = cnt_nxt[IDX_W-1:0];
  end

  // Single shared read port: CPU and dump engine never read in the same cycle.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < NB; i++)
        if (be[i]) mem[address[IDX_W-1:0]][8*i +: 8] <= wd[8*i +: 8];
    end
    if (mem_re) mem_q <= mem[mem_raddr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rd_valid_q <= 1'b0;
      rd_oob_q   <= 1'b0;
      oob_q      <= 1'b0;
      busy_q     <= 1'b0;
      dvalid_q   <= 1'b0;
      dlast_q    <= 1'b0;
      daddr_q    <= '0;
    end else begin
      rd_valid_q <= idle && re;
      rd_oob_q   <= idle && re && !cpu_inr;
      if (cpu_oob) oob_q <= 1'b1;
      case (state_q)
        IDLE: if (dump_start) begin
          state_q <= FETCH;
          busy_q  <= 1'b1;
          daddr_q <= '0;
        end
        FETCH: begin
          state_q  <= STREAM;
          dvalid_q <= 1'b1;
          dlast_q  <= at_last;
        end
        STREAM: if (dump_ready) begin
          if (at_last) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            dvalid_q <= 1'b0;
            dlast_q  <= 1'b0;
            daddr_q  <= '0;
          end else begin
            daddr_q <= cnt_nxt;
            dlast_q <= (cnt_nxt == LAST_ADDR);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Data outputs are gated by their valid flops so reset forces them to zero.
  assign rd         = (rd_valid_q && !rd_oob_q) ? mem_q : '0;
  assign rd_valid   = rd_valid_q;
  assign oob_err    = oob_q;
  assign dump_busy  = busy_q;
  assign dump_valid = dvalid_q;
  assign dump_addr  = daddr_q;
  assign dump_data  = dvalid_q ? mem_q : '0;
  assign dump_last  = dlast_q;

endmodule

// File: tb/tb_dmem_ram_stream.sv
// Random CPU traffic and dump streams on a 16-word instance, checked against an array model.
module tb_dmem_ram_stream;
  localparam int DW = 32, D = 16, AW = 32, CW = 4;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          we = 0, re = 0, dump_start = 0, dump_ready = 0;
  logic [3:0]    be = 0;
  logic [AW-1:0] address = 0;
  logic [DW-1:0] wd = 0, rd, dump_data;
  logic          rd_valid, oob_err, dump_busy, dump_valid, dump_last;
  logic [CW-1:0] dump_addr;

  logic [DW-1:0] model [D];
  bit            model_oob = 0;
  int            checks = 0, errors = 0;

  dmem_ram_stream #(.DATA_W(DW), .DEPTH(D), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .be(be), .re(re), .address(address), .wd(wd),
    .rd(rd), .rd_valid(rd_valid), .oob_err(oob_err), .dump_start(dump_start),
    .dump_busy(dump_busy), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_addr(dump_addr), .dump_data(dump_data), .dump_last(dump_last));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_rd"}, {rd_valid, rd}, 0);
    chk({tag, "_flags"}, {oob_err, dump_busy, dump_valid, dump_last}, 0);
    chk({tag, "_dump"}, {dump_addr, dump_data}, 0);
  endtask

  // One CPU cycle: drive, clock, compare against the model, release inputs.
  task automatic cpu_op(input bit w, input logic [3:0] b, input bit r,
                        input logic [31:0] a, input logic [31:0] d);
    logic [31:0] exp_rd;
    bit inr;
    inr = (a < D);
    exp_rd = (r && inr) ? model[a] : 32'h0;
    if (w && inr)
      for (int i = 0; i < 4; i++) if (b[i]) model[a][8*i +: 8] = d[8*i +: 8];
    if ((w || r) && !inr) model_oob = 1;
    we = w; be = b; re = r; address = a; wd = d;
    tick();
    we = 0; re = 0;
    chk("rd_valid", rd_valid, r);
    if (r) chk("rd", rd, exp_rd);
    chk("oob_err", oob_err, model_oob);
  endtask

  task automatic run_dump(input bit rand_ready, input int abort_after, input bit poke);
    int got = 0, cyc = 1, first_v = -1, last_cyc = -1;
    bit held = 0;
    logic [DW-1:0] hold_d = 0;
    logic [CW-1:0] hold_a = 0;
    dump_start = 1;
    tick();
    dump_start = 0;
    chk("fetch_state", {dump_busy, dump_valid}, 2'b10);
    while (got < D && cyc < 200) begin
      if (abort_after > 0 && got == abort_after) begin
        #2 rst_n = 0;
        #1 chk_reset_outs("async_rst");
        tick();
        chk_reset_outs("rst_hold");
        rst_n = 1;
        model_oob = 0;
        dump_ready = 0;
        tick();
        chk("no_emit_after_rst", {dump_busy, dump_valid}, 0);
        return;
      end
      dump_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (poke && cyc == 5) begin
        we = 1; be = 4'hF; address = 2; wd = $urandom;
      end else we = 0;
      if (held) chk("hold_stable", {dump_addr, dump_data}, {hold_a, hold_d});
      held = 0;
      if (dump_valid) begin
        if (first_v < 0) first_v = cyc;
        chk("busy_in_stream", dump_busy, 1);
        if (dump_ready) begin
          chk("dump_addr", dump_addr, got);
          chk("dump_data", dump_data, model[got]);
          chk("dump_last", dump_last, (got == D - 1));
          got++;
          last_cyc = cyc;
        end else begin
          held = 1; hold_a = dump_addr; hold_d = dump_data;
        end
      end
      tick();
      cyc++;
    end
    we = 0;
    chk("dump_count", got, D);
    chk("first_valid_cyc", first_v, 2);
    if (!rand_ready) chk("final_hs_cyc", last_cyc, D + 1);
    chk("busy_after", {dump_busy, dump_valid, dump_last}, 0);
  endtask

  initial begin
    #12;
    chk_reset_outs("reset");
    rst_n = 1;
    tick();
    for (int i = 0; i < D; i++) cpu_op(1, 4'hF, 0, i, $urandom);

    cpu_op(1, 4'hF, 0, 5, 32'hAABBCCDD);
    cpu_op(1, 4'h5, 0, 5, 32'h11223344);
    cpu_op(0, 4'h0, 1, 5, 0);
    chk("be_merge", rd, 32'hAA22CC44);
    cpu_op(0, 4'h0, 0, 0, 0);

    cpu_op(1, 4'hF, 0, 7, 32'h1);
    cpu_op(1, 4'hF, 1, 7, 32'h2);
    chk("rbw_old", rd, 32'h1);
    cpu_op(0, 4'h0, 1, 7, 0);
    chk("rbw_new", rd, 32'h2);

    for (int n = 0; n < 150; n++)
      cpu_op(1'($urandom), 4'($urandom), 1'($urandom), $urandom_range(0, D - 1), $urandom);

    cpu_op(1, 4'hF, 0, D, 32'hDEADBEEF);
    cpu_op(0, 4'h0, 1, D - 1, 0);
    for (int n = 0; n < 10; n++) cpu_op(0, 4'h0, 0, 0, 0);
    cpu_op(0, 4'h0, 1, 200000, 0);
    chk("oob_rd_zero", rd, 0);

    for (int n = 0; n < 100; n++)
      cpu_op(1'($urandom), 4'($urandom), 1'($urandom),
             ($urandom_range(0, 3) == 0) ? $urandom_range(D, 40) : $urandom_range(0, D - 1),
             $urandom);

    for (int i = 0; i < D; i++) cpu_op(1, 4'hF, 0, i, i * 3);
    run_dump(0, 0, 0);

    for (int i = 0; i < D; i++) cpu_op(1, 4'hF, 0, i, $urandom);
    run_dump(1, 0, 1);
    cpu_op(0, 4'h0, 1, 2, 0);

    run_dump(0, 4, 0);
    run_dump(0, 0, 0);
    cpu_op(0, 4'h0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
